// File: rtl/fetch_pkg.sv
// fetch_pkg: widths, opcode constants and fetch FSM encoding shared by the fetch stage and the control unit
package fetch_pkg;
  localparam int PC_W = 8;
  localparam int INSTR_W = 9;
  localparam logic [PC_W-1:0] RESET_PC = '0;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 9'h1B0;
  localparam logic [4:0] OP_HALT = 5'b11010;
  typedef enum logic [1:0] {IDLE, RUN, HALTED} fetch_state_e;
endpackage

// File: rtl/instr_fetch_stage_if.sv
// instr_fetch_stage_if: instruction-memory and decode-side signals of the fetch stage
interface instr_fetch_stage_if;
  import fetch_pkg::*;
  logic imem_en;
  logic [PC_W-1:0] imem_addr;
  logic [INSTR_W-1:0] imem_rdata;
  logic stall;
  logic redirect_valid;
  logic [PC_W-1:0] redirect_pc;
  logic halt_in;
  logic [INSTR_W-1:0] instr_out;
  logic [PC_W-1:0] pc_out;
  logic valid_out;
  logic halted;
  modport master (
    output imem_en, imem_addr, instr_out, pc_out, valid_out, halted,
    input imem_rdata, stall, redirect_valid, redirect_pc, halt_in
  );
  modport slave (
    input imem_en, imem_addr, instr_out, pc_out, valid_out, halted,
    output imem_rdata, stall, redirect_valid, redirect_pc, halt_in
  );
endinterface

// File: rtl/if_id_reg.sv
// if_id_reg: IF/ID pipeline register with hold and flush-to-bubble; invalid words load as a bubble
module if_id_reg
  import fetch_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_hold,
  input  logic               i_flush,
  input  logic               i_valid,
  input  logic [INSTR_W-1:0] i_instr,
  input  logic [PC_W-1:0]    i_pc,
  output logic [INSTR_W-1:0] o_instr,
  output logic [PC_W-1:0]    o_pc,
  output logic               o_valid
);
  logic [INSTR_W-1:0] r_instr;
  logic [PC_W-1:0] r_pc;
  logic r_valid;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || i_flush) begin
      r_instr <= NOP_INSTR;
      r_pc <= '0;
      r_valid <= 1'b0;
    end else if (!i_hold) begin
      r_instr <= i_valid ? i_instr : NOP_INSTR;
      r_pc <= i_valid ? i_pc : '0;
      r_valid <= i_valid;
    end
  end
  assign o_instr = r_instr;
  assign o_pc = r_pc;
  assign o_valid = r_valid;
endmodule

// File: rtl/instr_fetch_stage.sv
// instr_fetch_stage: PC/FSM owner driving synchronous imem and the IF/ID register.
// Optional IF_CYCLE_CNT_EN adds a saturating run_cycles counter.
module instr_fetch_stage
  import fetch_pkg::*;
(
  input logic clk,
  input logic rst_n,
  input logic start_req,
  instr_fetch_stage_if.master bus
`ifdef IF_CYCLE_CNT_EN
  ,
  output logic [15:0] run_cycles
`endif
);
  fetch_state_e r_state, w_state_nxt;
  logic [PC_W-1:0] r_fetch_pc, r_addr_q, w_fetch_pc_nxt, w_addr_q_nxt;
  logic r_pend, w_pend_nxt;
  logic w_run, w_start, w_halt, w_redir;
  assign w_run = r_state == RUN;
  assign w_start = start_req && !w_run;
  assign w_halt = w_run && bus.halt_in && bus.valid_out;
  assign w_redir = w_run && bus.redirect_valid && bus.valid_out && !w_halt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_fetch_pc <= RESET_PC;
      r_addr_q <= RESET_PC;
      r_pend <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_fetch_pc <= w_fetch_pc_nxt;
      r_addr_q <= w_addr_q_nxt;
      r_pend <= w_pend_nxt;
    end
  end
  always_comb begin
    w_state_nxt = r_state;
    w_fetch_pc_nxt = r_fetch_pc;
    w_addr_q_nxt = r_addr_q;
    w_pend_nxt = r_pend;
    if (w_start) begin
      w_state_nxt = RUN;
      w_fetch_pc_nxt = RESET_PC;
      w_addr_q_nxt = RESET_PC;
      w_pend_nxt = 1'b0;
    end else if (w_halt) begin
      w_state_nxt = HALTED;
      w_pend_nxt = 1'b0;
    end else if (w_redir) begin
      w_fetch_pc_nxt = bus.redirect_pc;
      w_pend_nxt = 1'b0;
    end else if (w_run && !bus.stall) begin
      w_addr_q_nxt = r_fetch_pc;
      w_fetch_pc_nxt = r_fetch_pc + PC_W'(1);
      w_pend_nxt = 1'b1;
    end
  end
  // A stall re-reads the in-flight address so imem_rdata still matches addr_q on release
  assign bus.imem_en = w_run;
  assign bus.imem_addr = bus.stall ? r_addr_q : r_fetch_pc;
  assign bus.halted = !w_run;
  if_id_reg u_if_id (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_hold  (!w_run || bus.stall),
    .i_flush (w_start || w_halt || w_redir),
    .i_valid (r_pend),
    .i_instr (bus.imem_rdata),
    .i_pc    (r_addr_q),
    .o_instr (bus.instr_out),
    .o_pc    (bus.pc_out),
    .o_valid (bus.valid_out)
  );
`ifdef IF_CYCLE_CNT_EN
  logic [15:0] r_run_cycles;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || w_start) r_run_cycles <= '0;
    else if (w_run && r_run_cycles != 16'hFFFF) r_run_cycles <= r_run_cycles + 16'd1;
  end
  assign run_cycles = r_run_cycles;
`endif
endmodule
